fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline. Sits directly upstream of the hazard detection unit.
- Holds the PC register and predicts the next PC with a direct-mapped BTB of 2-bit saturating counters.
- Drives instruction memory and owns the IF/ID pipeline register.
- Consumes the hazard unit's pc_write / if_id_write / if_flush controls and the EX-stage branch resolution; produces the fetched instruction, its PC and its prediction for ID.

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register with BTB-based next-PC prediction,
// instruction memory address drive and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BTB_IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        if_id_write,
  input  logic        if_flush,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target,
  output logic        if_id_valid
);

  localparam int          ENTRIES  = 1 << BTB_IDX_BITS;
  localparam int          TAG_BITS = 30 - BTB_IDX_BITS;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef logic [BTB_IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0]     tag_t;

  logic [31:0]        pc;
  logic [ENTRIES-1:0] btb_valid;
  tag_t               btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [1:0]         btb_ctr    [ENTRIES];

  idx_t        lk_idx;
  tag_t        lk_tag;
  logic        lk_hit;
  logic        pred_taken;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  idx_t        up_idx;
  tag_t        up_tag;
  logic        up_hit;
  logic        up_train;
  logic        up_alloc;
  logic        up_tgt_wr;
  logic [1:0]  up_ctr;
  logic [1:0]  ctr_next;

  logic        unused_upd_lsb;

  assign unused_upd_lsb = ^upd_pc[1:0];

  assign imem_addr = pc;

  assign lk_idx     = pc[BTB_IDX_BITS+1:2];
  assign lk_tag     = pc[31:BTB_IDX_BITS+2];
  assign lk_hit     = btb_valid[lk_idx]
                   && (btb_tag[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && btb_ctr[lk_idx][1];
  assign pc_plus4   = pc + 32'd4;
  assign next_pc    = pred_taken ? btb_target[lk_idx]
                                 : pc_plus4;

  assign up_idx    = upd_pc[BTB_IDX_BITS+1:2];
  assign up_tag    = upd_pc[31:BTB_IDX_BITS+2];
  assign up_hit    = btb_valid[up_idx]
                  && (btb_tag[up_idx] == up_tag);
  assign up_train  = upd_valid && up_hit;
  assign up_alloc  = upd_valid && !up_hit && upd_taken;
  assign up_tgt_wr = up_alloc || (up_train && upd_taken);
  assign up_ctr    = btb_ctr[up_idx];

  // saturating counter step in the resolved direction
  always_comb begin
    ctr_next = up_ctr;
    unique case (1'b1)
      upd_taken && (up_ctr != 2'b11):
        ctr_next = up_ctr + 2'd1;
      !upd_taken && (up_ctr != 2'b00):
        ctr_next = up_ctr - 2'd1;
      default: ;
    endcase
  end

  // BTB valid bits and counters; writes land after this cycle's lookup
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_ctr[i] <= 2'b01;
      end
    end else if (up_alloc) begin
      btb_valid[up_idx] <= 1'b1;
      btb_ctr[up_idx]   <= 2'b10;
    end else if (up_train) begin
      btb_ctr[up_idx] <= ctr_next;
    end
  end

  // BTB tag/target payload, qualified by the valid bits above
  always_ff @(posedge clk) begin
    if (!reset && up_tgt_wr) begin
      btb_target[up_idx] <= upd_target;
    end
    if (!reset && up_alloc) begin
      btb_tag[up_idx] <= up_tag;
    end
  end

  // PC register: redirect overrides a stall
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (ex_redirect) begin
      pc <= ex_redirect_pc;
    end else if (pc_write) begin
      pc <= next_pc;
    end
  end

  // IF/ID register: bubble on flush/redirect, beats hold
  always_ff @(posedge clk) begin
    if (reset || if_flush || ex_redirect) begin
      if_id_pc          <= '0;
      if_id_inst        <= NOP;
      if_id_pred_taken  <= 1'b0;
      if_id_pred_target <= '0;
      if_id_valid       <= 1'b0;
    end else if (if_id_write) begin
      if_id_pc          <= pc;
      if_id_inst        <= imem_inst;
      if_id_pred_taken  <= pred_taken;
      if_id_pred_target <= next_pc;
      if_id_valid       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run
// against a behavioural BTB/fetch reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // control pattern {reset, pc_write, if_id_write, if_flush, ex_redirect}
  localparam logic [4:0] RUN  = 5'b01100;
  localparam logic [4:0] STL  = 5'b00000;
  localparam logic [4:0] RDS  = 5'b00001;
  localparam logic [4:0] RDR  = 5'b01101;
  localparam logic [4:0] FLS  = 5'b00110;
  localparam logic [4:0] FLH  = 5'b01010;
  localparam logic [4:0] RSTX = 5'b11111;
  // update pattern {upd_valid, upd_taken}
  localparam logic [1:0] NOU = 2'b00;
  localparam logic [1:0] UT  = 2'b11;
  localparam logic [1:0] UN  = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;
  logic        if_id_valid;

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage #(
    .RESET_PC     (32'h0000_0000),
    .BTB_IDX_BITS (5)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .if_flush          (if_flush),
    .ex_redirect       (ex_redirect),
    .ex_redirect_pc    (ex_redirect_pc),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .imem_addr         (imem_addr),
    .imem_inst         (imem_inst),
    .if_id_pc          (if_id_pc),
    .if_id_inst        (if_id_inst),
    .if_id_pred_taken  (if_id_pred_taken),
    .if_id_pred_target (if_id_pred_target),
    .if_id_valid       (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  assign imem_inst = inst_of(imem_addr);

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] rpc;
    logic [1:0]  upd;
    logic [31:0] upc;
    logic [31:0] utg;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ipc;
    logic        pt;
    logic [31:0] tgt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [4:0] c, input logic [31:0] rpc,
                     input logic [1:0] u, input logic [31:0] upc,
                     input logic [31:0] utg, input logic [31:0] addr,
                     input logic v, input logic [31:0] ipc,
                     input logic pt, input logic [31:0] tgt);
    vec_t r;
    r.ctl = c; r.rpc = rpc; r.upd = u; r.upc = upc; r.utg = utg;
    r.addr = addr; r.v = v; r.ipc = ipc; r.pt = pt; r.tgt = tgt;
    tbl.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [31:0] addr,
                           input logic v, input logic [31:0] ipc,
                           input logic [31:0] inst, input logic pt,
                           input logic [31:0] tgt);
    chk({nm, " imem_addr"}, imem_addr, addr);
    chk({nm, " valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({nm, " if_id_pc"}, if_id_pc, ipc);
    chk({nm, " if_id_inst"}, if_id_inst, inst);
    chk({nm, " pred_taken"}, {31'd0, if_id_pred_taken}, {31'd0, pt});
    chk({nm, " pred_target"}, if_id_pred_target, tgt);
  endtask

  // reference model state
  logic [31:0] m_pc, m_ipc, m_inst, m_tgt;
  logic        m_v, m_pt;
  bit          mb_v   [32];
  int unsigned mb_tag [32];
  logic [31:0] mb_tgt [32];
  int          mb_ctr [32];

  task automatic model_edge();
    int unsigned i, t, ui, ut;
    logic        p;
    logic [31:0] np;
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        mb_v[k] = 1'b0;
        mb_ctr[k] = 1;
      end
      m_pc = 32'h0;
      m_v = 1'b0; m_ipc = 32'h0; m_inst = NOP;
      m_pt = 1'b0; m_tgt = 32'h0;
      return;
    end
    i  = (m_pc / 4) % 32;
    t  = m_pc / 128;
    p  = mb_v[i] && (mb_tag[i] == t) && (mb_ctr[i] >= 2);
    np = p ? mb_tgt[i] : m_pc + 32'd4;
    if (if_flush || ex_redirect) begin
      m_v = 1'b0; m_ipc = 32'h0; m_inst = NOP;
      m_pt = 1'b0; m_tgt = 32'h0;
    end else if (if_id_write) begin
      m_v = 1'b1; m_ipc = m_pc; m_inst = inst_of(m_pc);
      m_pt = p; m_tgt = np;
    end
    if (ex_redirect) m_pc = ex_redirect_pc;
    else if (pc_write) m_pc = np;
    if (upd_valid) begin
      ui = (upd_pc / 4) % 32;
      ut = upd_pc / 128;
      if (mb_v[ui] && mb_tag[ui] == ut) begin
        if (upd_taken) begin
          mb_ctr[ui] = (mb_ctr[ui] < 3) ? mb_ctr[ui] + 1 : 3;
          mb_tgt[ui] = upd_target;
        end else begin
          mb_ctr[ui] = (mb_ctr[ui] > 0) ? mb_ctr[ui] - 1 : 0;
        end
      end else if (upd_taken) begin
        mb_v[ui] = 1'b1;
        mb_tag[ui] = ut;
        mb_tgt[ui] = upd_target;
        mb_ctr[ui] = 2;
      end
    end
  endtask

  initial begin
    vec_t r;
    reset = 1'b1; pc_write = 1'b0; if_id_write = 1'b0;
    if_flush = 1'b0; ex_redirect = 1'b0; ex_redirect_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0;
    tick();
    tick();
    check_out("reset", 32'h0, 1'b0, 32'h0, NOP, 1'b0, 32'h0);

    // free run, stall, train, redirect, saturation, flush, reset
    add(RUN, 0, NOU, 0, 0, 'h4, 1'b1, 'h0, 1'b0, 'h4);
    add(RUN, 0, NOU, 0, 0, 'h8, 1'b1, 'h4, 1'b0, 'h8);
    add(RUN, 0, NOU, 0, 0, 'hC, 1'b1, 'h8, 1'b0, 'hC);
    add(RUN, 0, NOU, 0, 0, 'h10, 1'b1, 'hC, 1'b0, 'h10);
    add(STL, 0, NOU, 0, 0, 'h10, 1'b1, 'hC, 1'b0, 'h10);
    add(STL, 0, NOU, 0, 0, 'h10, 1'b1, 'hC, 1'b0, 'h10);
    add(RUN, 0, NOU, 0, 0, 'h14, 1'b1, 'h10, 1'b0, 'h14);
    add(RUN, 0, UT, 'h20, 'h100, 'h18, 1'b1, 'h14, 1'b0, 'h18);
    add(RUN, 0, NOU, 0, 0, 'h1C, 1'b1, 'h18, 1'b0, 'h1C);
    add(RUN, 0, NOU, 0, 0, 'h20, 1'b1, 'h1C, 1'b0, 'h20);
    add(RUN, 0, NOU, 0, 0, 'h100, 1'b1, 'h20, 1'b1, 'h100);
    add(RUN, 0, NOU, 0, 0, 'h104, 1'b1, 'h100, 1'b0, 'h104);
    add(RDS, 'h200, NOU, 0, 0, 'h200, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, NOU, 0, 0, 'h204, 1'b1, 'h200, 1'b0, 'h204);
    add(RDR, 'h20, NOU, 0, 0, 'h20, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, UN, 'h20, 0, 'h100, 1'b1, 'h20, 1'b1, 'h100);
    add(RDR, 'h20, UN, 'h20, 0, 'h20, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, NOU, 0, 0, 'h24, 1'b1, 'h20, 1'b0, 'h24);
    add(RUN, 0, UT, 'h20, 'h100, 'h28, 1'b1, 'h24, 1'b0, 'h28);
    add(RUN, 0, UT, 'h20, 'h100, 'h2C, 1'b1, 'h28, 1'b0, 'h2C);
    add(RUN, 0, UT, 'h20, 'h100, 'h30, 1'b1, 'h2C, 1'b0, 'h30);
    add(RUN, 0, UT, 'h20, 'h100, 'h34, 1'b1, 'h30, 1'b0, 'h34);
    add(RUN, 0, UT, 'h20, 'h100, 'h38, 1'b1, 'h34, 1'b0, 'h38);
    add(RUN, 0, UN, 'h20, 0, 'h3C, 1'b1, 'h38, 1'b0, 'h3C);
    add(RDR, 'h20, NOU, 0, 0, 'h20, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, NOU, 0, 0, 'h100, 1'b1, 'h20, 1'b1, 'h100);
    add(FLS, 0, NOU, 0, 0, 'h100, 1'b0, 'h0, 1'b0, 'h0);
    add(FLH, 0, NOU, 0, 0, 'h104, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, NOU, 0, 0, 'h108, 1'b1, 'h104, 1'b0, 'h108);
    add(RSTX, 'h300, UT, 'h20, 'h100, 'h0, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, NOU, 0, 0, 'h4, 1'b1, 'h0, 1'b0, 'h4);
    add(RDR, 'h20, NOU, 0, 0, 'h20, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, NOU, 0, 0, 'h24, 1'b1, 'h20, 1'b0, 'h24);
    add(RDR, 'hFFFF_FFFC, NOU, 0, 0, 'hFFFF_FFFC, 1'b0, 'h0, 1'b0, 'h0);
    add(RUN, 0, NOU, 0, 0, 'h0, 1'b1, 'hFFFF_FFFC, 1'b0, 'h0);

    for (int n = 0; n < tbl.size(); n++) begin
      r = tbl[n];
      {reset, pc_write, if_id_write, if_flush, ex_redirect} = r.ctl;
      ex_redirect_pc = r.rpc;
      {upd_valid, upd_taken} = r.upd;
      upd_pc = r.upc;
      upd_target = r.utg;
      tick();
      check_out($sformatf("row%0d", n), r.addr, r.v, r.ipc,
                r.v ? inst_of(r.ipc) : NOP, r.pt, r.tgt);
    end

    // randomized run against the reference model
    reset = 1'b1; pc_write = 1'b1; if_id_write = 1'b1;
    if_flush = 1'b0; ex_redirect = 1'b0; upd_valid = 1'b0;
    model_edge();
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      pc_write    = ($urandom_range(0, 3) != 0);
      if_id_write = ($urandom_range(0, 3) != 0);
      if_flush    = ($urandom_range(0, 9) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0)
        ex_redirect_pc = $urandom() & 32'hFFFF_FFFC;
      else
        ex_redirect_pc = $urandom_range(0, 127) * 4;
      upd_valid  = ($urandom_range(0, 2) == 0);
      upd_pc     = $urandom_range(0, 127) * 4;
      upd_taken  = ($urandom_range(0, 2) != 0);
      upd_target = $urandom_range(0, 127) * 4;
      model_edge();
      tick();
      check_out($sformatf("rnd%0d", c), m_pc, m_v, m_ipc,
                m_inst, m_pt, m_tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
